dsram_arbiter: RTL

- Shares the single-port synchronous data SRAM between two requesters: port 0 is the load/store path (execute/memory stages) and port 1 is the instruction-fetch refill path.
- Performs fixed-priority arbitration in favour of port 0, with a starvation guard for port 1 and a lock for atomic read-modify-write sequences.
- Routes the one-cycle-latency read data back to whichever port issued the read.
- Sits between the pipeline and the SRAM macro.

---
 rtl/dsram_arbiter_pkg.sv | 11 +
 rtl/dsram_arbiter_if.sv | 55 +++++
 rtl/dsram_arb_prio.sv | 29 ++
 rtl/dsram_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/dsram_arbiter_pkg.sv
// Shared constants and helpers for the data-SRAM arbiter.
package dsram_arbiter_pkg;

  localparam logic P_LSU = 1'b0;
  localparam logic P_IF  = 1'b1;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dsram_arbiter_if.sv
// Bundles both requester ports and the SRAM macro side of the arbiter.
interface dsram_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = dsram_arbiter_pkg::strb_w(DATA_W);

  logic              p0_req;
  logic              p0_wr;
  logic [STRB_W-1:0] p0_wstrb;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_lock;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_wr;
  logic [STRB_W-1:0] p1_wstrb;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              sram_en;
  logic [STRB_W-1:0] sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  p0_req, p0_wr, p0_wstrb, p0_addr, p0_wdata, p0_lock,
    input  p1_req, p1_wr, p1_wstrb, p1_addr, p1_wdata,
    input  sram_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata, busy
  );

  // Pipeline / SRAM macro side.
  modport master (
    output p0_req, p0_wr, p0_wstrb, p0_addr, p0_wdata, p0_lock,
    output p1_req, p1_wr, p1_wstrb, p1_addr, p1_wdata,
    output sram_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata, busy
  );

endinterface

// File: rtl/dsram_arb_prio.sv
// Combinational grant logic: lock, then starvation guard, then fixed priority to port 0.
module dsram_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             i_p0_req,
  input  logic             i_p1_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  input  logic             i_lock_held,
  output logic             o_p0_gnt,
  output logic             o_p1_gnt
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_p0_gnt = 1'b0;
    o_p1_gnt = 1'b0;
    if (i_lock_held) begin
      o_p0_gnt = i_p0_req;
    end else if (i_p1_req && (i_starve_cnt >= CNT_W'(STARVE_LIMIT))) begin
      o_p1_gnt = 1'b1;
    end else if (i_p0_req) begin
      o_p0_gnt = 1'b1;
    end else if (i_p1_req) begin
      o_p1_gnt = 1'b1;
    end
  end

endmodule

// File: rtl/dsram_arbiter.sv
// Shares the single-port data SRAM between the load/store path (port 0) and I-fetch refill (port 1).
module dsram_arbiter
  import dsram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic            clk,
  input  logic            reset,
  dsram_arbiter_if.slave  bus
);

  localparam int STRB_W = strb_w(DATA_W);

  logic             w_p0_req;
  logic             w_p1_req;
  logic             w_p0_gnt;
  logic             w_p1_gnt;
  logic             w_rd_gnt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_lock_held;
  logic             r_resp_pend;
  logic             r_resp_owner;

  logic              w_sram_en;
  logic [STRB_W-1:0] w_sram_wen;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [DATA_W-1:0] w_sram_wdata;

  // Requests are masked while reset is high so no grant leaks out during reset.
  assign w_p0_req = bus.p0_req & ~reset;
  assign w_p1_req = bus.p1_req & ~reset;

  dsram_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_prio (
    .i_p0_req     (w_p0_req),
    .i_p1_req     (w_p1_req),
    .i_starve_cnt (r_starve_cnt),
    .i_lock_held  (r_lock_held),
    .o_p0_gnt     (w_p0_gnt),
    .o_p1_gnt     (w_p1_gnt)
  );

  assign w_rd_gnt = (w_p0_gnt && !bus.p0_wr) || (w_p1_gnt && !bus.p1_wr);

  always_comb begin
    w_sram_en    = 1'b0;
    w_sram_wen   = '0;
    w_sram_addr  = '0;
    w_sram_wdata = '0;
    if (w_p0_gnt) begin
      w_sram_en    = 1'b1;
      w_sram_wen   = bus.p0_wr ? bus.p0_wstrb : '0;
      w_sram_addr  = bus.p0_addr;
      w_sram_wdata = bus.p0_wdata;
    end else if (w_p1_gnt) begin
      w_sram_en    = 1'b1;
      w_sram_wen   = bus.p1_wr ? bus.p1_wstrb : '0;
      w_sram_addr  = bus.p1_addr;
      w_sram_wdata = bus.p1_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_starve_cnt <= '0;
      r_lock_held  <= 1'b0;
      r_resp_pend  <= 1'b0;
      r_resp_owner <= P_LSU;
    end else begin
      if (w_p1_gnt || !w_p1_req) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt < CNT_W'(STARVE_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      if (w_p0_gnt) begin
        r_lock_held <= bus.p0_lock;
      end else if (!bus.p0_req && !bus.p0_lock) begin
        r_lock_held <= 1'b0;
      end

      r_resp_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_resp_owner <= w_p1_gnt ? P_IF : P_LSU;
      end
    end
  end

  assign bus.p0_gnt     = w_p0_gnt;
  assign bus.p1_gnt     = w_p1_gnt;
  assign bus.p0_rvalid  = r_resp_pend && (r_resp_owner == P_LSU);
  assign bus.p1_rvalid  = r_resp_pend && (r_resp_owner == P_IF);
  assign bus.p0_rdata   = bus.p0_rvalid ? bus.sram_rdata : '0;
  assign bus.p1_rdata   = bus.p1_rvalid ? bus.sram_rdata : '0;
  assign bus.sram_en    = w_sram_en;
  assign bus.sram_wen   = w_sram_wen;
  assign bus.sram_addr  = w_sram_addr;
  assign bus.sram_wdata = w_sram_wdata;
  assign bus.busy       = r_resp_pend | r_lock_held;

endmodule
